// File: rtl/store_narrow_unit.sv
// Store narrowing unit: truncates a register value to byte/half/word and writes it
// into a word-only data memory, using read-modify-write for sub-word stores.
module store_narrow_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [1:0]            size_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           writeData_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  misaligned_o,
    output logic [ADDR_WIDTH-1:0] memAddr_o,
    output logic                  memRead_o,
    output logic                  memWrite_o,
    output logic [31:0]           memWriteData_o,
    input  logic [31:0]           memReadData_i,
    input  logic                  memReady_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } state_t;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              size_q, size_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [31:0]             word_q, word_d;
    logic                    done_q, done_d;
    logic                    mis_q, mis_d;
    logic                    busy_q, busy_d;
    logic                    memRead_q, memRead_d;
    logic                    memWrite_q, memWrite_d;
    logic                    alignOk;
    logic                    startAccept;

    // Replace only the addressed little-endian lane of the word read back from memory.
    function automatic logic [31:0] mergeLane(input logic [31:0] oldWord,
                                              input logic [15:0] newData,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
        logic [31:0] result;
        result = oldWord;
        if (size == SIZE_HALF) begin
            if (lane[1]) begin
                result[31:16] = newData;
            end else begin
                result[15:0] = newData;
            end
        end else begin
            case (lane)
                2'd0:    result[7:0]   = newData[7:0];
                2'd1:    result[15:8]  = newData[7:0];
                2'd2:    result[23:16] = newData[7:0];
                default: result[31:24] = newData[7:0];
            endcase
        end
        return result;
    endfunction

    always_comb begin
        alignOk = 1'b0;
        case (size_i)
            SIZE_WORD: alignOk = (addr_i[1:0] == 2'b00);
            SIZE_HALF: alignOk = ~addr_i[0];
            SIZE_BYTE: alignOk = 1'b1;
            default:   alignOk = 1'b0;
        endcase
    end

    assign startAccept = (state_q == IDLE) && start_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i && alignOk) begin
                    state_d = (size_i == SIZE_WORD) ? WRITE : READ;
                end
            end
            READ: begin
                if (memReady_i) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (memReady_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is computed one cycle ahead so that all of them leave flops.
    always_comb begin
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        done_d     = 1'b0;
        mis_d      = 1'b0;
        busy_d     = (state_d == READ) || (state_d == WRITE);
        memRead_d  = (state_d == READ);
        memWrite_d = (state_d == WRITE);
        if (startAccept) begin
            addr_d  = addr_i;
            size_d  = size_i;
            wdata_d = writeData_i[15:0];
            if (!alignOk) begin
                done_d = 1'b1;
                mis_d  = 1'b1;
            end else if (size_i == SIZE_WORD) begin
                word_d = writeData_i;
            end
        end
        if ((state_q == READ) && memReady_i) begin
            word_d = mergeLane(memReadData_i, wdata_q, size_q, addr_q[1:0]);
        end
        if ((state_q == WRITE) && memReady_i) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            size_q     <= 2'b00;
            wdata_q    <= 16'h0000;
            word_q     <= 32'h0000_0000;
            done_q     <= 1'b0;
            mis_q      <= 1'b0;
            busy_q     <= 1'b0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            done_q     <= done_d;
            mis_q      <= mis_d;
            busy_q     <= busy_d;
            memRead_q  <= memRead_d;
            memWrite_q <= memWrite_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign misaligned_o   = mis_q;
    assign memRead_o      = memRead_q;
    assign memWrite_o     = memWrite_q;
    assign memWriteData_o = word_q;
    assign memAddr_o      = {addr_q[ADDR_WIDTH-1:2], 2'b00};

endmodule

// File: tb/tb_store_narrow_unit.sv
// Testbench for store_narrow_unit: table of directed stores against a small memory
// responder with configurable wait states, plus reset and back-to-back sequences.
module tb_store_narrow_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic [31:0] memAddr;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        memReady;

    int testsRun    = 0;
    int testsFailed = 0;

    int          waitCycles = 0;
    int          waitCnt    = 0;
    logic [31:0] memWord    = 32'h0;
    int          readCount  = 0;
    int          writeCount = 0;
    int          overlapCount = 0;
    logic [31:0] lastRAddr, lastWAddr, lastWData, firstWAddr, firstWData;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memWord;
        int          waitC;
        int          expDone;
        logic        expMis;
        int          expReads;
        int          expWrites;
        logic [31:0] expAddr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[10];

    store_narrow_unit #(.ADDR_WIDTH(32)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .size_i         (size),
        .addr_i         (addr),
        .writeData_i    (writeData),
        .busy_o         (busy),
        .done_o         (done),
        .misaligned_o   (misaligned),
        .memAddr_o      (memAddr),
        .memRead_o      (memRead),
        .memWrite_o     (memWrite),
        .memWriteData_o (memWriteData),
        .memReadData_i  (memReadData),
        .memReady_i     (memReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memReadData = memWord;

    // Memory responder: holds MemReady low for waitCycles cycles of each access and
    // logs every access that will be accepted at the coming rising edge.
    always @(negedge clk) begin
        if (memRead || memWrite) begin
            if (waitCnt < waitCycles) begin
                memReady = 1'b0;
                waitCnt++;
            end else begin
                memReady = 1'b1;
                waitCnt = 0;
            end
        end else begin
            memReady = 1'b0;
            waitCnt = 0;
        end
        if (memRead && memWrite) overlapCount++;
        if (memRead && memReady) begin
            readCount++;
            lastRAddr = memAddr;
        end
        if (memWrite && memReady) begin
            if (writeCount == 0) begin
                firstWAddr = memAddr;
                firstWData = memWriteData;
            end
            writeCount++;
            lastWAddr = memAddr;
            lastWData = memWriteData;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic clearLogs();
        readCount  = 0;
        writeCount = 0;
        lastRAddr  = 32'h0;
        lastWAddr  = 32'h0;
        lastWData  = 32'h0;
        firstWAddr = 32'h0;
        firstWData = 32'h0;
    endtask

    // Presents one request so that it is sampled at the next rising edge (E0).
    task automatic applyStimulus(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        start     = 1'b1;
        size      = s;
        addr      = a;
        writeData = d;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic runVector(input int idx);
        int   doneCycle;
        logic misAtDone;
        doneCycle = -1;
        misAtDone = 1'b0;
        clearLogs();
        waitCycles = vecs[idx].waitC;
        memWord    = vecs[idx].memWord;
        applyStimulus(vecs[idx].size, vecs[idx].addr, vecs[idx].wdata);
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            #1;
            if (cyc == 1) begin
                checkOutput($sformatf("v%0d busy c1", idx), 32'(busy), 32'(!vecs[idx].expMis));
            end
            if (done) begin
                doneCycle = cyc;
                misAtDone = misaligned;
                break;
            end
        end
        checkOutput($sformatf("v%0d done cycle", idx), 32'(doneCycle), 32'(vecs[idx].expDone));
        checkOutput($sformatf("v%0d misaligned", idx), 32'(misAtDone), 32'(vecs[idx].expMis));
        checkOutput($sformatf("v%0d reads", idx), 32'(readCount), 32'(vecs[idx].expReads));
        checkOutput($sformatf("v%0d writes", idx), 32'(writeCount), 32'(vecs[idx].expWrites));
        if (vecs[idx].expReads > 0) begin
            checkOutput($sformatf("v%0d read addr", idx), lastRAddr, vecs[idx].expAddr);
        end
        if (vecs[idx].expWrites > 0) begin
            checkOutput($sformatf("v%0d write addr", idx), lastWAddr, vecs[idx].expAddr);
            checkOutput($sformatf("v%0d write data", idx), lastWData, vecs[idx].expData);
        end
        @(negedge clk);
        #1;
        checkOutput($sformatf("v%0d done pulse", idx), 32'(done), 32'h0);
        checkOutput($sformatf("v%0d idle busy", idx), 32'(busy), 32'h0);
    endtask

    initial begin
        int doneSeen;

        vecs[0] = '{2'b00, 32'h100, 32'hDEADBEEF, 32'h0,        0, 2, 1'b0, 0, 1, 32'h100, 32'hDEADBEEF};
        vecs[1] = '{2'b10, 32'h203, 32'h123456AB, 32'h11223344, 2, 7, 1'b0, 1, 1, 32'h200, 32'hAB223344};
        vecs[2] = '{2'b01, 32'h302, 32'hFFFFCAFE, 32'h55667788, 0, 3, 1'b0, 1, 1, 32'h300, 32'hCAFE7788};
        vecs[3] = '{2'b01, 32'h101, 32'h12345678, 32'h0,        0, 1, 1'b1, 0, 0, 32'h0,   32'h0};
        vecs[4] = '{2'b00, 32'h102, 32'h12345678, 32'h0,        0, 1, 1'b1, 0, 0, 32'h0,   32'h0};
        vecs[5] = '{2'b11, 32'h400, 32'h12345678, 32'h0,        0, 1, 1'b1, 0, 0, 32'h0,   32'h0};
        vecs[6] = '{2'b10, 32'h200, 32'h000000EE, 32'h11223344, 0, 3, 1'b0, 1, 1, 32'h200, 32'h112233EE};
        vecs[7] = '{2'b10, 32'h201, 32'h000000FF, 32'h00000000, 1, 5, 1'b0, 1, 1, 32'h200, 32'h0000FF00};
        vecs[8] = '{2'b01, 32'h500, 32'h12345678, 32'hAAAAAAAA, 0, 3, 1'b0, 1, 1, 32'h500, 32'hAAAA5678};
        vecs[9] = '{2'b00, 32'h604, 32'hCAFEF00D, 32'h0,        1, 3, 1'b0, 0, 1, 32'h604, 32'hCAFEF00D};

        rst_n     = 1'b0;
        start     = 1'b0;
        size      = 2'b00;
        addr      = 32'h0;
        writeData = 32'h0;
        memReady  = 1'b0;

        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset misaligned", 32'(misaligned), 32'h0);
        checkOutput("reset memRead", 32'(memRead), 32'h0);
        checkOutput("reset memWrite", 32'(memWrite), 32'h0);
        checkOutput("reset memAddr", memAddr, 32'h0);
        checkOutput("reset memWriteData", memWriteData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            runVector(i);
        end

        // Reset while a write is stalled: requests drop at once, no Done afterwards.
        clearLogs();
        waitCycles = 100;
        applyStimulus(2'b00, 32'h100, 32'h5A5A5A5A);
        @(negedge clk);
        #1;
        checkOutput("rst mid-write memWrite before", 32'(memWrite), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst mid-write memWrite", 32'(memWrite), 32'h0);
        checkOutput("rst mid-write busy", 32'(busy), 32'h0);
        checkOutput("rst mid-write memAddr", memAddr, 32'h0);
        checkOutput("rst mid-write memWriteData", memWriteData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            #1;
            if (done || busy) doneSeen++;
        end
        checkOutput("rst after release done/busy", 32'(doneSeen), 32'h0);
        checkOutput("rst after release writes", 32'(writeCount), 32'h0);

        // Back-to-back: Start while busy is dropped, Start in the Done cycle is taken.
        clearLogs();
        waitCycles = 0;
        applyStimulus(2'b00, 32'h700, 32'h11111111);
        @(negedge clk);
        #1;
        checkOutput("b2b busy c1", 32'(busy), 32'h1);
        start     = 1'b1;
        size      = 2'b00;
        addr      = 32'h704;
        writeData = 32'h22222222;
        @(negedge clk);
        #1;
        checkOutput("b2b done c2", 32'(done), 32'h1);
        addr      = 32'h708;
        writeData = 32'h33333333;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("b2b busy c3", 32'(busy), 32'h1);
        checkOutput("b2b memWrite c3", 32'(memWrite), 32'h1);
        @(negedge clk);
        #1;
        checkOutput("b2b done c4", 32'(done), 32'h1);
        checkOutput("b2b write count", 32'(writeCount), 32'h2);
        checkOutput("b2b first addr", firstWAddr, 32'h700);
        checkOutput("b2b first data", firstWData, 32'h11111111);
        checkOutput("b2b second addr", lastWAddr, 32'h708);
        checkOutput("b2b second data", lastWData, 32'h33333333);

        checkOutput("read/write overlap", 32'(overlapCount), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
